// File: rtl/sd_data_tx.sv
// SD DAT0 block serializer: start bit, DATA_STRING payload bytes MSB-first,
// CRC16 (poly 0x1021, init 0) and end bit. Payload is pulled with Byte_Req.
module sd_data_tx #(
  parameter int DATA_STRING = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Start,
  input  logic        Abort,
  output logic        Byte_Req,
  input  logic [7:0]  Byte_Data,
  output logic        DAT_Out,
  output logic        DAT_OE,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] CRC,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_CRC   = 3'd4,
    S_END   = 3'd5
  } state_t;

  localparam int CW = $clog2(DATA_STRING) + 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(DATA_STRING - 1);

  state_t        state;
  logic [6:0]    shreg;     // bits still to send of the current byte
  logic [2:0]    bit_idx;
  logic [CW-1:0] byte_cnt;
  logic [14:0]   crc_sh;    // bits still to send of the final CRC
  logic [3:0]    crc_cnt;
  logic          fb;
  logic [15:0]   crc_next;

  // DAT_Out carries the bit on the wire this cycle, so it feeds the CRC.
  always_comb begin
    fb       = DAT_Out ^ CRC[15];
    crc_next = {CRC[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  end

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      byte_cnt <= '0;
      crc_sh   <= '0;
      crc_cnt  <= '0;
      CRC      <= 16'h0000;
      Byte_Req <= 1'b0;
      DAT_Out  <= 1'b1;
      DAT_OE   <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      Byte_Req <= 1'b0;
      Done     <= 1'b0;
      if (state != S_IDLE && Abort) begin
        state   <= S_IDLE;
        DAT_OE  <= 1'b0;
        DAT_Out <= 1'b1;
        Busy    <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (Start) begin
              state    <= S_FETCH;
              CRC      <= 16'h0000;
              byte_cnt <= '0;
              Byte_Req <= 1'b1;
              DAT_OE   <= 1'b1;
              DAT_Out  <= 1'b1;
              Busy     <= 1'b1;
            end
          end
          S_FETCH: begin
            state   <= S_START;
            DAT_Out <= 1'b0;
          end
          S_START: begin
            state   <= S_DATA;
            shreg   <= Byte_Data[6:0];
            DAT_Out <= Byte_Data[7];
            bit_idx <= 3'd0;
          end
          S_DATA: begin
            CRC     <= crc_next;
            bit_idx <= bit_idx + 3'd1;
            // Request lands in bit 6 so the byte is held during bit 7.
            if (bit_idx == 3'd5 && byte_cnt != LAST_BYTE) Byte_Req <= 1'b1;
            if (bit_idx == 3'd7) begin
              if (byte_cnt == LAST_BYTE) begin
                state   <= S_CRC;
                crc_sh  <= crc_next[14:0];
                DAT_Out <= crc_next[15];
                crc_cnt <= 4'd0;
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
                shreg    <= Byte_Data[6:0];
                DAT_Out  <= Byte_Data[7];
              end
            end else begin
              shreg   <= {shreg[5:0], 1'b0};
              DAT_Out <= shreg[6];
            end
          end
          S_CRC: begin
            crc_cnt <= crc_cnt + 4'd1;
            if (crc_cnt == 4'd15) begin
              state   <= S_END;
              DAT_Out <= 1'b1;
            end else begin
              crc_sh  <= {crc_sh[13:0], 1'b0};
              DAT_Out <= crc_sh[14];
            end
          end
          S_END: begin
            state   <= S_IDLE;
            Done    <= 1'b1;
            Busy    <= 1'b0;
            DAT_OE  <= 1'b0;
            DAT_Out <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_data_tx.sv
// Bench for sd_data_tx: a 4-byte and a 512-byte instance share the clock;
// sel picks which one is stimulated and observed.
module tb_sd_data_tx;

  logic clk, rst_n, start, abort, sel;
  logic [7:0] byte_data;
  logic dat_a, oe_a, busy_a, done_a, req_a;
  logic dat_b, oe_b, busy_b, done_b, req_b;
  logic [15:0] crc_a, crc_b;
  logic [2:0] dbg_a, dbg_b;
  logic start_a, start_b, abort_a, abort_b;
  logic dat_s, oe_s, busy_s, done_s, req_s;
  logic [15:0] crc_s;

  int checks = 0;
  int errors = 0;
  logic [7:0] pay [512];

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign abort_a = abort & ~sel;
  assign abort_b = abort & sel;
  assign dat_s  = sel ? dat_b  : dat_a;
  assign oe_s   = sel ? oe_b   : oe_a;
  assign busy_s = sel ? busy_b : busy_a;
  assign done_s = sel ? done_b : done_a;
  assign req_s  = sel ? req_b  : req_a;
  assign crc_s  = sel ? crc_b  : crc_a;

  sd_data_tx #(.DATA_STRING(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .Start(start_a), .Abort(abort_a),
    .Byte_Req(req_a), .Byte_Data(byte_data), .DAT_Out(dat_a), .DAT_OE(oe_a),
    .Busy(busy_a), .Done(done_a), .CRC(crc_a), .dbg_state(dbg_a)
  );

  sd_data_tx #(.DATA_STRING(512)) dut_b (
    .clk(clk), .rst_n(rst_n), .Start(start_b), .Abort(abort_b),
    .Byte_Req(req_b), .Byte_Data(byte_data), .DAT_Out(dat_b), .DAT_OE(oe_b),
    .Busy(busy_b), .Done(done_b), .CRC(crc_b), .dbg_state(dbg_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // CRC as the remainder of M(x)*x^16 divided by x^16+x^12+x^5+1.
  function automatic logic [15:0] ref_crc(input int nbits);
    logic [16:0] r;
    bit b;
    r = '0;
    for (int i = 0; i < nbits + 16; i++) begin
      b = (i < nbits) ? pay[i / 8][7 - (i % 8)] : 1'b0;
      r = {r[15:0], b};
      if (r[16]) r = r ^ 17'h11021;
    end
    return r[15:0];
  endfunction

  // Starts a block and checks every cycle; stop_at>0 returns early at that cycle.
  task automatic run_block(input bit big, input bit keep_start, input int stop_at,
                           input int glitch_at, output int busy_n, output int req_n,
                           output logic [15:0] got_crc);
    int n, len, lim, idx, hold, mism, req_bad;
    logic [15:0] model, crc_at;
    bit q[$];
    n = big ? 512 : 4;
    len = 8 * n + 19;
    lim = (stop_at > 0) ? stop_at : len;
    model = ref_crc(8 * n);
    q = {};
    q.push_back(1'b1);
    q.push_back(1'b0);
    for (int i = 0; i < 8 * n; i++) q.push_back(pay[i / 8][7 - (i % 8)]);
    for (int j = 15; j >= 0; j--) q.push_back(model[j]);
    q.push_back(1'b1);
    idx = 0; hold = 0; mism = 0; req_bad = 0; busy_n = 0; req_n = 0; crc_at = 'x;
    sel = big;
    byte_data = 8'($urandom);
    start = 1'b1;
    for (int c = 1; c <= lim; c++) begin
      @(posedge clk); #1;
      start = keep_start || (c == glitch_at);
      if (hold > 0) begin
        hold--;
        if (hold == 0) byte_data = 8'($urandom);
      end
      if (dat_s !== q[c-1] || oe_s !== 1'b1 || busy_s !== 1'b1 || done_s !== 1'b0) mism++;
      if (busy_s === 1'b1) busy_n++;
      if (req_s === 1'b1) begin
        req_n++;
        if (!(c == 1 || (c >= 9 && (c - 9) % 8 == 0 && (c - 9) / 8 <= n - 2))) req_bad++;
        if (idx < n) byte_data = pay[idx];
        idx++;
        hold = 2;
      end
      if (c == 3 + 8 * n) crc_at = crc_s;
    end
    chk("stream", mism, 0);
    chk("req_position", req_bad, 0);
    got_crc = crc_s;
    if (stop_at == 0) begin
      chk("crc_first_crc_cycle", crc_at, model);
      @(posedge clk); #1;
      chk("done_cycle", {dat_s, oe_s, busy_s, done_s, req_s}, 5'b10010);
      chk("crc_after_done", crc_s, model);
      got_crc = crc_s;
    end
  endtask

  typedef struct {
    bit          big;
    int          mode;     // 0 fill, 1 handshake pattern, 2 random
    logic [7:0]  fill;
    bit          fixed;
    logic [15:0] exp_crc;
    int          exp_busy;
    int          exp_req;
  } vec_t;

  initial begin
    vec_t tbl[6];
    logic [7:0] hs [4];
    int bn, rn, cnt_req, cnt_done, cnt_oe;
    logic [15:0] gc;

    tbl[0] = '{big: 1'b1, mode: 0, fill: 8'hFF, fixed: 1'b1, exp_crc: 16'h7FA1, exp_busy: 4115, exp_req: 512};
    tbl[1] = '{big: 1'b1, mode: 0, fill: 8'h00, fixed: 1'b1, exp_crc: 16'h0000, exp_busy: 4115, exp_req: 512};
    tbl[2] = '{big: 1'b0, mode: 1, fill: 8'h00, fixed: 1'b0, exp_crc: 16'h0000, exp_busy: 51, exp_req: 4};
    tbl[3] = '{big: 1'b0, mode: 2, fill: 8'h00, fixed: 1'b0, exp_crc: 16'h0000, exp_busy: 51, exp_req: 4};
    tbl[4] = '{big: 1'b0, mode: 2, fill: 8'h00, fixed: 1'b0, exp_crc: 16'h0000, exp_busy: 51, exp_req: 4};
    tbl[5] = '{big: 1'b0, mode: 0, fill: 8'hFF, fixed: 1'b0, exp_crc: 16'h0000, exp_busy: 51, exp_req: 4};
    hs[0] = 8'hA5; hs[1] = 8'h5A; hs[2] = 8'h3C; hs[3] = 8'hC3;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; sel = 1'b0; byte_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_a", {dat_a, oe_a, busy_a, done_a, req_a, crc_a, dbg_a}, {5'b10000, 16'h0000, 3'd0});
    chk("reset_b", {dat_b, oe_b, busy_b, done_b, req_b, crc_b, dbg_b}, {5'b10000, 16'h0000, 3'd0});
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 512; i++) begin
        case (tbl[t].mode)
          0: pay[i] = tbl[t].fill;
          1: pay[i] = hs[i % 4];
          default: pay[i] = 8'($urandom);
        endcase
      end
      run_block(tbl[t].big, 1'b0, 0, 0, bn, rn, gc);
      chk("busy_len", bn, tbl[t].exp_busy);
      chk("req_count", rn, tbl[t].exp_req);
      if (tbl[t].fixed) chk("crc_table", gc, tbl[t].exp_crc);
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end

    // Back-to-back: Start held through Done, second block independent.
    for (int i = 0; i < 4; i++) pay[i] = 8'($urandom);
    run_block(1'b0, 1'b1, 0, 0, bn, rn, gc);
    for (int i = 0; i < 4; i++) pay[i] = 8'($urandom);
    run_block(1'b0, 1'b0, 0, 0, bn, rn, gc);
    chk("b2b_busy_len", bn, 51);
    repeat (2) @(posedge clk);
    #1;

    // Abort at byte 10 bit 3 with a Start pulse while busy.
    for (int i = 0; i < 512; i++) pay[i] = 8'($urandom);
    run_block(1'b1, 1'b0, 86, 30, bn, rn, gc);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_outputs", {dat_s, oe_s, busy_s, done_s, req_s}, 5'b10000);
    chk("abort_crc_partial", crc_s, ref_crc(83));
    cnt_req = 0; cnt_done = 0; cnt_oe = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (req_s === 1'b1) cnt_req++;
      if (done_s === 1'b1) cnt_done++;
      if (oe_s !== 1'b0) cnt_oe++;
    end
    chk("abort_quiet", {cnt_req[7:0], cnt_done[7:0], cnt_oe[7:0]}, 0);

    // Reset at data bit 100, then a clean block.
    run_block(1'b1, 1'b0, 103, 0, bn, rn, gc);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {dat_s, oe_s, busy_s, done_s, req_s, crc_s}, {5'b10000, 16'h0000});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt_done = 0; cnt_oe = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done_s === 1'b1) cnt_done++;
      if (oe_s !== 1'b0 || busy_s !== 1'b0) cnt_oe++;
    end
    chk("reset_no_resume", {cnt_done[7:0], cnt_oe[7:0]}, 0);
    for (int i = 0; i < 512; i++) pay[i] = 8'($urandom);
    run_block(1'b1, 1'b0, 0, 0, bn, rn, gc);
    chk("restart_busy_len", bn, 4115);
    chk("restart_req_count", rn, 512);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_data_tx.md
# sd_data_tx

Serializes one SD data block onto the single-bit DAT0 line during a write. Each block is a start bit, DATA_STRING bytes MSB-first, a 16-bit CRC and an end bit. The block fetches payload bytes from an upstream byte source with a request/latch handshake. It computes the bit-serial CRC16 over the payload while shifting, using the same polynomial and initial value as M_CRC16, and appends the CRC after the payload. It sits between the write-data buffer and the SD DAT0 pad.

## Interface
- DATA_STRING, 512: payload bytes per block; must be ≥1.
- clk  in  1  system clock; one DAT bit per cycle.
- rst_n  in  1  asynchronous, active-low reset.
- Start  in  1  begin a block; sampled only in S_IDLE.
- Abort  in  1  synchronous; terminates a block in progress.
- Byte_Req  out  1  one-cycle request for the next payload byte.
- Byte_Data  in  8  payload byte; latched at the rising edge that ends the cycle after Byte_Req.
- DAT_Out  out  1  serial data to the pad.
- DAT_OE  out  1  pad output enable.
- Busy  out  1  high from S_FETCH through S_END.
- Done  out  1  one-cycle pulse after a completed block.
- CRC  out  16  CRC of the current/last payload.

## Operation
- States: S_IDLE, S_FETCH, S_START, S_DATA, S_CRC, S_END.
- **S_IDLE:** DAT_Out=1, DAT_OE=0. Start=1 moves to S_FETCH, clears CRC to 0x0000 and clears the byte counter.
- **S_FETCH (1 cycle):** Byte_Req=1, DAT_Out=1, DAT_OE=1. Next state is S_START.
- **S_START (1 cycle):** DAT_Out=0. Byte_Data is latched into the shift register at the end of this cycle. Next state is S_DATA.
- **S_DATA (8·DATA_STRING cycles):**
  - DAT_Out = shift register bit 7; the register shifts left each cycle.
  - Bit index 0..7 counts from the MSB.
  - During bit index 6 of byte k (k < DATA_STRING−1), Byte_Req=1. Byte_Data is latched at the end of bit 7 and becomes byte k+1.
  - No request is issued during the last byte. Byte_Req pulses exactly DATA_STRING times per block.
- **CRC update per transmitted data bit:** fb = DAT_Out ^ CRC[15]; CRC ← {CRC[14:0],1'b0} ^ (fb ? 16'h1021 : 0). The register is 16 bits and overflow is discarded.
- **S_CRC (16 cycles):** DAT_Out = final CRC, MSB first. The CRC output stays frozen.
- **S_END (1 cycle):** DAT_Out=1 as the end bit, then go to S_IDLE. Done=1 and Busy=0 in that first S_IDLE cycle; DAT_OE=0.
- The byte counter is $clog2(DATA_STRING)+1 bits wide. The last-byte compare is against DATA_STRING−1.
- Start while Busy is ignored.
- Start in the Done cycle is accepted, giving back-to-back blocks.
- **Abort in any busy state:** next cycle is S_IDLE with DAT_OE=0, DAT_Out=1, Byte_Req=0 and no Done pulse. CRC holds its partial value. Abort takes priority over every transition.
- **rst_n low:** all state and outputs are cleared immediately, mid-block included.
  - Reset values: DAT_Out=1, DAT_OE=0, Busy=0, Done=0, Byte_Req=0, CRC=16'h0000, state=S_IDLE.
  - Nothing resumes after reset.

## Timing
- All outputs are registered.
- Start sampled at edge e leads to S_FETCH in cycle e+1 and the start bit in cycle e+2. The first data bit is in cycle e+3.
- Busy lasts 8·DATA_STRING+19 cycles: 4115 for 512.
- **Byte_Req handshake:** Byte_Req is high in cycle c. The source must hold Byte_Data stable in cycle c+1, and the block samples it at the rising edge that ends c+1. There is no back-pressure, so the source must always respond.
- The final CRC is valid from the first S_CRC cycle until the next accepted Start.

## Test plan
- **Reset:** assert rst_n=0 mid-block, bit 100 of a transfer → outputs return to reset values asynchronously; no Done; the block restarts cleanly on the next Start.
- **All-ones payload:** DATA_STRING=512, all bytes 0xFF → DAT carries 0, 4096 ones, 16'h7FA1 MSB-first, then 1. CRC=16'h7FA1; Busy for 4115 cycles; a single Done pulse.
- **All-zeros payload:** 512 bytes of 0x00 → CRC=16'h0000; the 16 CRC bits are all 0.
- **Handshake timing:** DATA_STRING=4, bytes 0xA5, 0x5A, 0x3C, 0xC3 → Byte_Req in S_FETCH and at bit 6 of bytes 0–2, so 4 pulses. The DAT bit stream and the CRC match a bench reference model of the polynomial.
- **Abort and ignored Start:** Abort at byte 10, bit 3 → DAT_OE=0 next cycle, no Done, no further Byte_Req. Start pulsed while Busy → no effect on the stream.
- **Back-to-back blocks:** Start held high through Done → second S_FETCH in the cycle after Done. The CRC is restarted from 0 and the second block's CRC is correct independently.
